// File: rtl/queue_burst_reader_pkg.sv
// Shared types and register map for the queue burst reader.
package queue_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, RELEASE} state_t;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  localparam int ST_UNDERFLOW = 8;
  localparam int ST_STALL     = 9;
  localparam int ST_BUSY      = 10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_TH_LSB = 4;
  localparam int CTRL_TH_MSB = 8;
  localparam int TH_W        = CTRL_TH_MSB - CTRL_TH_LSB + 1;

endpackage

// File: rtl/stage_fifo.sv
// Single-clock first-word-fall-through staging FIFO; count is one bit wider than the pointers.
module stage_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The burst gate upstream guarantees room for a whole burst before it starts.
  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/queue_burst_reader.sv
// Drains BURST_LEN samples from the queue on each interrupt into a staging FIFO read over APB.
module queue_burst_reader
  import queue_reader_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int STAGE_DEPTH = 16,
  parameter int THRESH_RST  = 4
) (
  input  logic        sys_clk,
  input  logic        PRESETn,
  input  logic        q_interrupt,
  input  logic [15:0] q_data,
  output logic        q_read,
  output logic        q_enable,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq_out
);

  localparam int CW = $clog2(STAGE_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            en_q, under_q, stall_q, irq_q;
  logic [TH_W-1:0] thresh_q, wr_thresh;
  logic            stall_set;

  logic            acc_rd, acc_wr, pop, fifo_empty;
  logic [15:0]     fifo_dout;
  logic [CW-1:0]   count, free;
  logic            unused_pwdata;

  assign acc_rd    = PSEL && PENABLE && !PWRITE;
  assign acc_wr    = PSEL && PENABLE && PWRITE;
  assign pop       = acc_rd && (PADDR == ADDR_DATA) && !fifo_empty;
  assign free      = CW'(STAGE_DEPTH) - count;
  assign PREADY    = 1'b1;
  assign irq_out   = irq_q;
  assign wr_thresh = PWDATA[CTRL_TH_MSB:CTRL_TH_LSB];
  assign unused_pwdata = ^{PWDATA[31:10], PWDATA[3:1]};

  stage_fifo #(.WIDTH(16), .DEPTH(STAGE_DEPTH)) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (PRESETn),
    .push_i  (q_read),
    .pop_i   (pop),
    .din_i   (q_data),
    .dout_o  (fifo_dout),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  ()
  );

  always_ff @(posedge sys_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Once in READ the burst runs to completion regardless of q_interrupt or en.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    q_read    = 1'b0;
    q_enable  = 1'b0;
    stall_set = 1'b0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (en_q && q_interrupt) begin
          if (free >= CW'(BURST_LEN)) state_d = READ;
          else                        stall_set = 1'b1;
        end
      end
      READ: begin
        q_read = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BURST_LEN - 1)) state_d = RELEASE;
      end
      RELEASE: begin
        q_enable = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge PRESETn) begin
    if (!PRESETn) begin
      en_q     <= 1'b0;
      thresh_q <= TH_W'(THRESH_RST);
      under_q  <= 1'b0;
      stall_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (acc_wr && PADDR == ADDR_CTRL) begin
        en_q     <= PWDATA[CTRL_EN];
        thresh_q <= (int'(wr_thresh) > STAGE_DEPTH) ? TH_W'(STAGE_DEPTH) : wr_thresh;
      end
      // Flag sets take priority over a same-cycle W1C.
      if (acc_rd && PADDR == ADDR_DATA && fifo_empty) under_q <= 1'b1;
      else if (acc_wr && PADDR == ADDR_STATUS && PWDATA[ST_UNDERFLOW]) under_q <= 1'b0;
      if (stall_set) stall_q <= 1'b1;
      else if (acc_wr && PADDR == ADDR_STATUS && PWDATA[ST_STALL]) stall_q <= 1'b0;
      irq_q <= en_q && (thresh_q != '0) && (int'(count) >= int'(thresh_q));
    end
  end

  always_comb begin
    PRDATA = '0;
    if (acc_rd) begin
      case (PADDR)
        ADDR_DATA:   if (!fifo_empty) PRDATA[15:0] = fifo_dout;
        ADDR_STATUS: begin
          PRDATA[CW-1:0]       = count;
          PRDATA[ST_UNDERFLOW] = under_q;
          PRDATA[ST_STALL]     = stall_q;
          PRDATA[ST_BUSY]      = (state_q != IDLE);
        end
        ADDR_CTRL: begin
          PRDATA[CTRL_EN]                 = en_q;
          PRDATA[CTRL_TH_MSB:CTRL_TH_LSB] = thresh_q;
        end
        default: PRDATA = '0;
      endcase
    end
  end

endmodule
